stage_wb: RTL and testbench
===========================

// Module: stage_wb
// PURPOSE
//   Writeback stage directly downstream of the memory stage. Holds one instruction, waits for
//   the load response, aligns and sign/zero-extends load data, then issues one register-file
//   write. Also drives forwarding outputs and applies back-pressure to the memory stage.
// PARAMETERS
//   Width        32  datapath width (= rvcpu::Width)
//   LoadTimeout  16  max cycles in WAIT_RSP before abandoning a load (>=2)
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous, active-low reset
//   in_valid     in   1      memory stage presents an instruction
//   in_ready     out  1      stage accepts; transfer = in_valid & in_ready
//   rd           in   5      rvcpu::reg_t destination register
//   rd_valid     in   1      instruction writes rd
//   rd_data      in   Width  non-load result from memory stage
//   is_load      in   1      instruction is a load
//   op           in   4      rvcpu::operation_t; op[2:0] = funct3
//   addr_lo      in   2      byte offset of load address
//   flush        in   1      discard in-flight instruction
//   mem_rvalid   in   1      load response valid
//   mem_rdata    in   Width  raw aligned-word load data
//   wb_we        out  1      register-file write enable
//   wb_rd        out  5      register-file write index
//   wb_data      out  Width  register-file write data
//   fwd_valid    out  1      fwd_rd/fwd_data valid for bypass (= wb_we)
//   fwd_rd       out  5      = wb_rd
//   fwd_data     out  Width  = wb_data
//   busy         out  1      state != IDLE
//   load_err     out  1      one-cycle pulse: load abandoned on timeout
// BEHAVIOUR
//   - Reset (rst=0 at clk edge): state=IDLE; wb_we=0, wb_rd=0, wb_data=0, load_err=0, counter=0.
//     Reset overrides all inputs, including mid-load.
//   - FSM states: IDLE, WAIT_RSP, WRITE. in_ready=1 in IDLE and WRITE, 0 in WAIT_RSP.
//   - Accept (IDLE or WRITE, in_valid=1, flush=0):
//     - non-load: next state WRITE; latch rd and rd_data.
//     - load: next state WAIT_RSP; latch rd, rd_valid, op[2:0], addr_lo; counter=0.
//   - WAIT_RSP: mem_rvalid is sampled from the cycle after accept.
//     - mem_rvalid=1: next state WRITE; wb_data = formatted mem_rdata.
//     - else counter++; when counter==LoadTimeout-1 with no response: next state IDLE,
//       load_err=1 for one cycle, no write.
//   - mem_rvalid outside WAIT_RSP is ignored, including late responses after flush or timeout.
//   - WRITE: wb_we = latched rd_valid & (rd!=0), asserted for exactly one cycle.
//     An accept in the same cycle chains to the next state; otherwise next state IDLE.
//   - Latency: non-load accept@N -> wb_we@N+1. Load rvalid@M -> wb_we@M+1.
//   - Load formatting by funct3 (b=byte addr_lo, h=half addr_lo[1]):
//     000 LB sext8, 001 LH sext16, 100 LBU zext8, 101 LHU zext16, 010/other LW full word.
//     Misaligned LH/LHU (addr_lo[0]=1) uses half addr_lo[1]; no trap.
//   - flush=1: next state IDLE, no accept that cycle, no wb_we next cycle.
//     The write for the instruction already in WRITE still completes this cycle.
//     flush has priority over mem_rvalid and the timeout.
//   - Outputs are registered except in_ready/busy (decoded from state) and fwd_* (aliases of wb_*).
// TESTING
//   1. Reset: drive rst=0 for 2 cycles with in_valid=1 -> wb_we=0, in_ready=1, busy=0, wb_data=0.
//   2. Back-to-back ALU ops rd=5 data=0x11 then rd=6 data=0x22 -> wb_we on consecutive cycles,
//      in_ready held at 1.
//   3. LB addr_lo=3, rdata=0x80FF_0000 -> wb_data=0xFFFF_FF80.
//      LHU addr_lo=2, same rdata -> wb_data=0x0000_80FF.
//   4. Load with rd=0 and rvalid 3 cycles after accept -> in_ready=0 for 3 cycles,
//      then no wb_we, state returns to IDLE.
//   5. Load with no response, LoadTimeout=16 -> load_err pulses once, no write.
//      A later stray mem_rvalid is ignored.
//   6. flush in WAIT_RSP with mem_rvalid in the same cycle -> no wb_we, state=IDLE next cycle.

Source files
------------

// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - writeback stage: load response wait, load formatting, register-file write
module stage_wb #(
  parameter int Width       = 32,
  parameter int LoadTimeout = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rd,
  input  logic             rd_valid,
  input  logic [Width-1:0] rd_data,
  input  logic             is_load,
  input  logic [3:0]       op,
  input  logic [1:0]       addr_lo,
  input  logic             flush,
  input  logic             mem_rvalid,
  input  logic [Width-1:0] mem_rdata,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [Width-1:0] wb_data,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [Width-1:0] fwd_data,
  output logic             busy,
  output logic             load_err
);

  localparam int CntW = (LoadTimeout > 2) ? $clog2(LoadTimeout) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LoadTimeout - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RSP, WRITE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_valid_q, rd_valid_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [Width-1:0] wb_data_q, wb_data_d;
  logic             load_err_q, load_err_d;

  logic unused_op;
  assign unused_op = op[3];

  // Selects the addressed byte/half of the raw word and extends it per funct3.
  function automatic logic [Width-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [Width-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{(Width-8){b[7]}}, b};
      3'b001:  fmt_load = {{(Width-16){h[15]}}, h};
      3'b100:  fmt_load = {{(Width-8){1'b0}}, b};
      3'b101:  fmt_load = {{(Width-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  assign in_ready  = (state_q != WAIT_RSP);
  assign busy      = (state_q != IDLE);
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign load_err  = load_err_q;
  assign fwd_valid = wb_we_q;
  assign fwd_rd    = wb_rd_q;
  assign fwd_data  = wb_data_q;

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    rd_valid_d = rd_valid_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    cnt_d      = cnt_q;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    load_err_d = 1'b0;
    case (state_q)
      WAIT_RSP: begin
        // flush wins over both a response and the timeout in the same cycle
        if (flush) begin
          state_d = IDLE;
        end else if (mem_rvalid) begin
          state_d   = WRITE;
          wb_we_d   = rd_valid_q & (rd_q != 5'd0);
          wb_rd_d   = rd_q;
          wb_data_d = fmt_load(funct3_q, addr_lo_q, mem_rdata);
        end else if (cnt_q == CntLast) begin
          state_d    = IDLE;
          load_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        // IDLE and WRITE both accept; a WRITE with no accept drains to IDLE
        if (flush || !in_valid) begin
          state_d = IDLE;
        end else if (is_load) begin
          state_d    = WAIT_RSP;
          rd_d       = rd;
          rd_valid_d = rd_valid;
          funct3_d   = op[2:0];
          addr_lo_d  = addr_lo;
          cnt_d      = '0;
        end else begin
          state_d    = WRITE;
          rd_d       = rd;
          rd_valid_d = rd_valid;
          wb_we_d    = rd_valid & (rd != 5'd0);
          wb_rd_d    = rd;
          wb_data_d  = rd_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      cnt_q      <= '0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      cnt_q      <= cnt_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// tb/tb_stage_wb.sv - self-checking bench for stage_wb
module tb_stage_wb;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, rd_valid, is_load, flush, mem_rvalid;
  logic [4:0]  rd, wb_rd, fwd_rd;
  logic [31:0] rd_data, mem_rdata, wb_data, fwd_data;
  logic [3:0]  op;
  logic [1:0]  addr_lo;
  logic        wb_we, fwd_valid, busy, load_err;
  int          passed = 0;
  int          total = 0;

  stage_wb #(.Width(32), .LoadTimeout(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .rd(rd),
    .rd_valid(rd_valid), .rd_data(rd_data), .is_load(is_load), .op(op), .addr_lo(addr_lo),
    .flush(flush), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference load formatting: shift the addressed field down, mask, then extend arithmetically.
  function automatic logic [31:0] fmt_ref(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [31:0] v;
    int sh_b, sh_h;
    sh_b = int'(a) * 8;
    sh_h = (int'(a) / 2) * 16;
    case (f3)
      3'b000: begin v = (w >> sh_b) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'b001: begin v = (w >> sh_h) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'b100: v = (w >> sh_b) & 32'hFF;
      3'b101: v = (w >> sh_h) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; is_load = 1'b0; rd = 5'd5; rd_valid = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    tick(); tick();
    total++; if (wb_we !== 1'b0) $display("FAIL reset_we got %0b exp 0", wb_we); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
    total++; if (wb_data !== 32'h0) $display("FAIL reset_data got %h exp 0", wb_data); else passed++;
    total++; if (load_err !== 1'b0) $display("FAIL reset_err got %0b exp 0", load_err); else passed++;
    in_valid = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  r;
    logic        v;
    logic [31:0] d;
    in_valid = 1'b1; is_load = 1'b0; rd_valid = 1'b1; rd = 5'd5; rd_data = 32'h11;
    tick();
    total++; if (wb_we !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h11)
      $display("FAIL b2b_first got we=%0b rd=%0d data=%h exp 1 5 11", wb_we, wb_rd, wb_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready0 got %0b exp 1", in_ready); else passed++;
    rd = 5'd6; rd_data = 32'h22;
    tick();
    total++; if (wb_we !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'h22)
      $display("FAIL b2b_second got we=%0b rd=%0d data=%h exp 1 6 22", wb_we, wb_rd, wb_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %0b exp 1", in_ready); else passed++;
    for (int i = 0; i < 10; i++) begin
      r = 5'($urandom_range(0, 31)); v = 1'($urandom); d = $urandom;
      if (i == 3) r = 5'd0;
      rd = r; rd_valid = v; rd_data = d;
      tick();
      total++; if (wb_we !== (v && r != 5'd0) || fwd_valid !== wb_we)
        $display("FAIL b2b_rand_we got %0b/%0b exp %0b", wb_we, fwd_valid, v && r != 5'd0); else passed++;
      if (v && r != 5'd0) begin
        total++; if (wb_rd !== r || wb_data !== d || fwd_rd !== r || fwd_data !== d)
          $display("FAIL b2b_rand_data got rd=%0d data=%h exp %0d %h", wb_rd, wb_data, r, d); else passed++;
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (wb_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL b2b_drain got we=%0b busy=%0b exp 0 0", wb_we, busy); else passed++;
  endtask

  task automatic test_load_format();
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] w, exp_d;
    logic [4:0]  r;
    int          dly;
    for (int i = 0; i < 24; i++) begin
      if (i == 0) begin f3 = 3'b000; a = 2'd3; w = 32'h80FF_0000; exp_d = 32'hFFFF_FF80; end
      else if (i == 1) begin f3 = 3'b101; a = 2'd2; w = 32'h80FF_0000; exp_d = 32'h0000_80FF; end
      else begin
        f3 = 3'($urandom); a = 2'($urandom); w = $urandom; exp_d = fmt_ref(f3, a, w);
      end
      r = 5'($urandom_range(1, 31)); dly = $urandom_range(0, 5);
      in_valid = 1'b1; is_load = 1'b1; op = {1'b0, f3}; addr_lo = a; rd = r; rd_valid = 1'b1;
      tick();
      in_valid = 1'b0; is_load = 1'b0; addr_lo = 2'($urandom); op = 4'($urandom);
      for (int k = 0; k < dly; k++) begin
        mem_rdata = $urandom;
        total++; if (in_ready !== 1'b0 || wb_we !== 1'b0)
          $display("FAIL ld_wait got ready=%0b we=%0b exp 0 0", in_ready, wb_we); else passed++;
        tick();
      end
      mem_rvalid = 1'b1; mem_rdata = w;
      tick();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      total++; if (wb_we !== 1'b1 || wb_rd !== r || wb_data !== exp_d)
        $display("FAIL ld_fmt f3=%0d a=%0d w=%h got we=%0b rd=%0d data=%h exp 1 %0d %h",
                 f3, a, w, wb_we, wb_rd, wb_data, r, exp_d); else passed++;
      tick();
      total++; if (wb_we !== 1'b0 || busy !== 1'b0)
        $display("FAIL ld_done got we=%0b busy=%0b exp 0 0", wb_we, busy); else passed++;
    end
  endtask

  task automatic test_rd_zero();
    int low = 0;
    int writes = 0;
    in_valid = 1'b1; is_load = 1'b1; op = 4'b0010; addr_lo = 2'd0; rd = 5'd0; rd_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (in_ready === 1'b0) low++;
      if (k == 2) begin mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; end
      tick();
      if (wb_we !== 1'b0) writes++;
    end
    mem_rvalid = 1'b0;
    tick();
    if (wb_we !== 1'b0) writes++;
    total++; if (low != 3) $display("FAIL rd0_ready_low got %0d exp 3", low); else passed++;
    total++; if (writes != 0) $display("FAIL rd0_no_write got %0d exp 0", writes); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rd0_idle got %0b exp 0", busy); else passed++;
  endtask

  task automatic test_timeout();
    int first = -1;
    int pulses = 0;
    int writes = 0;
    in_valid = 1'b1; is_load = 1'b1; op = 4'b0000; rd = 5'd3; rd_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_load = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (load_err === 1'b1) begin pulses++; if (first < 0) first = i; end
      if (wb_we !== 1'b0) writes++;
    end
    total++; if (first != 16) $display("FAIL to_when got %0d exp 16", first); else passed++;
    total++; if (pulses != 1) $display("FAIL to_pulses got %0d exp 1", pulses); else passed++;
    total++; if (writes != 0) $display("FAIL to_writes got %0d exp 0", writes); else passed++;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    total++; if (wb_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL to_stray got we=%0b busy=%0b exp 0 0", wb_we, busy); else passed++;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; is_load = 1'b1; op = 4'b0010; rd = 5'd9; rd_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_load = 1'b0;
    tick();
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    total++; if (busy !== 1'b0 || wb_we !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_wait got busy=%0b we=%0b ready=%0b exp 0 0 1", busy, wb_we, in_ready); else passed++;
    tick();
    total++; if (wb_we !== 1'b0) $display("FAIL flush_wait_late got %0b exp 0", wb_we); else passed++;
    in_valid = 1'b1; rd = 5'd7; rd_data = 32'h77;
    tick();
    flush = 1'b1; rd = 5'd8; rd_data = 32'h88;
    total++; if (wb_we !== 1'b1 || wb_rd !== 5'd7)
      $display("FAIL flush_write_done got we=%0b rd=%0d exp 1 7", wb_we, wb_rd); else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (wb_we !== 1'b0 || busy !== 1'b0)
      $display("FAIL flush_write_next got we=%0b busy=%0b exp 0 0", wb_we, busy); else passed++;
  endtask

  task automatic test_reset_midload();
    in_valid = 1'b1; is_load = 1'b1; op = 4'b0010; rd = 5'd4; rd_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_load = 1'b0; rst = 1'b0; mem_rvalid = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || wb_we !== 1'b0)
      $display("FAIL rst_mid got busy=%0b ready=%0b we=%0b exp 0 1 0", busy, in_ready, wb_we); else passed++;
    rst = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    total++; if (wb_we !== 1'b0) $display("FAIL rst_mid_late got %0b exp 0", wb_we); else passed++;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; rd = '0; rd_valid = 1'b0; rd_data = '0; is_load = 1'b0;
    op = '0; addr_lo = '0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_load_format();
    test_rd_zero();
    test_timeout();
    test_flush();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
